llc_input_sched: RTL and testbench
==================================

// Module: llc_input_sched
// PURPOSE
//  Per-transaction input scheduler for the LLC pipeline. Each cycle in IDLE it picks one source
//  (reset, response, stalled request, DMA resume, rst/flush set walk, CPU request, DMA request)
//  from the LLC status flags, pops that input channel and pulses decode_en. It holds the grant
//  until process_done. It also owns the rst/flush set-walk counter that steps through every set.
// PARAMETERS
//  SETS      1024           number of LLC sets walked by a rst/flush
//  SET_BITS  $clog2(SETS)   width of walk_set
// PORTS
//  clk                    in   1         clock
//  rst                    in   1         synchronous, active-high reset
//  rst_in_valid           in   1         reset/flush request pending on input channel
//  rsp_in_valid           in   1         coherence response pending
//  req_in_valid           in   1         CPU request pending
//  dma_req_in_valid       in   1         DMA request pending
//  rst_stall              in   1         reset walk in progress
//  flush_stall            in   1         flush walk in progress
//  req_stall              in   1         a CPU request is blocked on its set
//  req_in_stalled_valid   in   1         a stalled CPU request is waiting to retry
//  recall_pending         in   1         recall outstanding; only responses are admitted
//  dma_read_pending       in   1         a multi-line DMA read is in flight
//  dma_write_pending      in   1         a multi-line DMA write is in flight
//  is_dma_resume          in   1         OR of the DMA read/write to-resume flags
//  process_done           in   1         the current transaction has retired in process
//  rst_in_ready           out  1         pop strobe for rst_in
//  rsp_in_ready           out  1         pop strobe for rsp_in
//  req_in_ready           out  1         pop strobe for req_in
//  dma_req_in_ready       out  1         pop strobe for dma_req_in
//  decode_en              out  1         one-cycle strobe: the granted transaction enters decode
//  grant                  out  7         one-hot registered grant, bit order = priority order below
//  walk_set               out  SET_BITS  set index for the current rst/flush walk step
//  walk_done              out  1         one-cycle strobe when the last set retires
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, walk_set 0, rr_ptr 0 (CPU first).
//  Reset has priority over every other input in the same cycle. Reset mid-BUSY aborts the
//  grant with no pops.
//  FSM states: IDLE, DECODE, BUSY.
//   IDLE: if any source is eligible, the winner's *_ready is asserted combinationally this
//         cycle, grant is registered, and the FSM goes to DECODE.
//   DECODE: decode_en=1 for exactly 1 cycle, then the FSM goes to BUSY.
//   BUSY: hold grant; when process_done=1, grant clears and the FSM goes to IDLE next cycle.
//         process_done outside BUSY is ignored.
//  Latency: channel valid in IDLE -> ready in the same cycle -> decode_en on the next cycle.
//  Minimum spacing between decode_en pulses is 3 cycles.
//  Eligibility, fixed priority, highest first:
//   0 RST:    rst_in_valid & !rst_stall & !flush_stall.
//   1 RSP:    rsp_in_valid. This is the only source eligible while recall_pending=1.
//   2 STALL:  req_in_stalled_valid & !req_stall. No pop.
//   3 DRES:   is_dma_resume. No pop.
//   4 WALK:   rst_stall | flush_stall. No pop.
//   5 REQ:    req_in_valid, with no stall/walk/recall flag set and no DMA pending.
//   6 DMA:    dma_req_in_valid, with no stall/walk/recall flag set and no DMA pending.
//  REQ vs DMA: round-robin.
//   - When both are eligible, rr_ptr chooses.
//   - rr_ptr toggles to the other source only when that tie-break grant is issued.
//   - A lone eligible source always wins and does not move rr_ptr.
//  Walk counter:
//   - On a WALK grant, walk_set is the set processed.
//   - On process_done of a WALK grant: walk_set+1; at SETS-1 it wraps to 0 and walk_done
//     pulses in the same cycle.
//   - A RST grant clears walk_set to 0.
//  A ready output is never asserted without its matching valid. At most one ready is high per
//  cycle.
// TESTING
//  1 rst=1 for 2 cycles -> all outputs 0. req_in_valid=1 -> req_in_ready@T, decode_en@T+1,
//    grant=7'b0100000.
//  2 req_in_valid=dma_req_in_valid=1 held, process_done 2 cycles after each decode_en ->
//    grants alternate REQ, DMA, REQ, DMA.
//  3 recall_pending=1, req_in_valid=1, rsp_in_valid=1 -> only rsp_in_ready is asserted;
//    req_in_ready stays 0 until recall_pending=0.
//  4 SETS=4, flush_stall=1 -> 4 WALK grants, walk_set 0,1,2,3; walk_done on the 4th
//    process_done; walk_set returns to 0.
//  5 rst asserted during BUSY -> next cycle all outputs 0 and state IDLE; the held grant is
//    never popped again.
//  6 rst_in_valid, rsp_in_valid and req_in_valid all high in IDLE -> rst_in_ready is the only
//    strobe that cycle.

Source files
------------

// File: rtl/llc_input_sched.sv
// llc_input_sched: per-transaction input scheduler for the LLC pipeline.
// Picks one source per IDLE cycle by fixed priority (REQ/DMA round-robin),
// pops the winning channel, pulses decode_en, holds the grant until
// process_done, and owns the rst/flush set-walk counter.
module llc_input_sched #(
    parameter int unsigned SETS     = 1024,
    parameter int unsigned SET_BITS = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rst_in_valid,
    input  logic                rsp_in_valid,
    input  logic                req_in_valid,
    input  logic                dma_req_in_valid,
    input  logic                rst_stall,
    input  logic                flush_stall,
    input  logic                req_stall,
    input  logic                req_in_stalled_valid,
    input  logic                recall_pending,
    input  logic                dma_read_pending,
    input  logic                dma_write_pending,
    input  logic                is_dma_resume,
    input  logic                process_done,
    output logic                rst_in_ready,
    output logic                rsp_in_ready,
    output logic                req_in_ready,
    output logic                dma_req_in_ready,
    output logic                decode_en,
    output logic [6:0]          grant,
    output logic [SET_BITS-1:0] walk_set,
    output logic                walk_done
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        BUSY
    } state_t;

    // Grant bit positions, highest priority first.
    localparam int unsigned SRC_RST   = 0;
    localparam int unsigned SRC_RSP   = 1;
    localparam int unsigned SRC_STALL = 2;
    localparam int unsigned SRC_DRES  = 3;
    localparam int unsigned SRC_WALK  = 4;
    localparam int unsigned SRC_REQ   = 5;
    localparam int unsigned SRC_DMA   = 6;

    localparam logic [SET_BITS-1:0] LAST_SET = SET_BITS'(SETS - 1);

    state_t     state;
    logic       rr_ptr;       // 0: CPU request wins the next tie, 1: DMA wins
    logic [6:0] elig;
    logic [6:0] pick;
    logic       pick_tie;
    logic       walk_active;
    logic       dma_pending;
    logic       new_ok;
    logic       launch;

    // Per-source eligibility; while a recall is outstanding only responses pass.
    always_comb begin
        walk_active = rst_stall | flush_stall;
        dma_pending = dma_read_pending | dma_write_pending;
        new_ok      = !walk_active && !req_stall && !recall_pending && !dma_pending;

        elig            = '0;
        elig[SRC_RST]   = rst_in_valid && !walk_active && !recall_pending;
        elig[SRC_RSP]   = rsp_in_valid;
        elig[SRC_STALL] = req_in_stalled_valid && !req_stall && !recall_pending;
        elig[SRC_DRES]  = is_dma_resume && !recall_pending;
        elig[SRC_WALK]  = walk_active && !recall_pending;
        elig[SRC_REQ]   = req_in_valid && new_ok;
        elig[SRC_DMA]   = dma_req_in_valid && new_ok;
    end

    // Fixed-priority pick; REQ and DMA share the lowest slot via rr_ptr.
    always_comb begin
        pick     = '0;
        pick_tie = 1'b0;
        if (elig[SRC_RST]) begin
            pick[SRC_RST] = 1'b1;
        end else if (elig[SRC_RSP]) begin
            pick[SRC_RSP] = 1'b1;
        end else if (elig[SRC_STALL]) begin
            pick[SRC_STALL] = 1'b1;
        end else if (elig[SRC_DRES]) begin
            pick[SRC_DRES] = 1'b1;
        end else if (elig[SRC_WALK]) begin
            pick[SRC_WALK] = 1'b1;
        end else if (elig[SRC_REQ] && elig[SRC_DMA]) begin
            pick_tie = 1'b1;
            if (rr_ptr) begin
                pick[SRC_DMA] = 1'b1;
            end else begin
                pick[SRC_REQ] = 1'b1;
            end
        end else if (elig[SRC_REQ]) begin
            pick[SRC_REQ] = 1'b1;
        end else if (elig[SRC_DMA]) begin
            pick[SRC_DMA] = 1'b1;
        end
    end

    // Pop strobes are combinational in the IDLE cycle that issues the grant.
    always_comb begin
        launch           = (state == IDLE) && !rst && (pick != '0);
        rst_in_ready     = launch && pick[SRC_RST];
        rsp_in_ready     = launch && pick[SRC_RSP];
        req_in_ready     = launch && pick[SRC_REQ];
        dma_req_in_ready = launch && pick[SRC_DMA];
    end

    // Scheduler FSM with registered grant/decode_en and the set-walk counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            decode_en <= 1'b0;
            rr_ptr    <= 1'b0;
            walk_set  <= '0;
            walk_done <= 1'b0;
        end else begin
            walk_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick != '0) begin
                        grant     <= pick;
                        decode_en <= 1'b1;
                        state     <= DECODE;
                        // Only a contested REQ/DMA grant hands the tie to the other side.
                        if (pick_tie) begin
                            rr_ptr <= pick[SRC_REQ];
                        end
                        if (pick[SRC_RST]) begin
                            walk_set <= '0;
                        end
                    end
                end
                DECODE: begin
                    decode_en <= 1'b0;
                    state     <= BUSY;
                end
                BUSY: begin
                    if (process_done) begin
                        grant <= '0;
                        state <= IDLE;
                        if (grant[SRC_WALK]) begin
                            if (walk_set == LAST_SET) begin
                                walk_set  <= '0;
                                walk_done <= 1'b1;
                            end else begin
                                walk_set <= walk_set + SET_BITS'(1);
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    decode_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_llc_input_sched.sv
// tb_llc_input_sched: table vectors, hand sequences and randomized traffic
// checked against a transaction-level reference model of the scheduler.
module tb_llc_input_sched;

    localparam int unsigned SETS     = 4;
    localparam int unsigned SET_BITS = 2;

    logic clk = 1'b0;
    logic rst, rst_in_valid, rsp_in_valid, req_in_valid, dma_req_in_valid;
    logic rst_stall, flush_stall, req_stall, req_in_stalled_valid, recall_pending;
    logic dma_read_pending, dma_write_pending, is_dma_resume, process_done;
    logic rst_in_ready, rsp_in_ready, req_in_ready, dma_req_in_ready, decode_en;
    logic [6:0] grant;
    logic [SET_BITS-1:0] walk_set;
    logic walk_done;

    int checks = 0;
    int errors = 0;

    llc_input_sched #(.SETS(SETS), .SET_BITS(SET_BITS)) dut (
        .clk(clk), .rst(rst),
        .rst_in_valid(rst_in_valid), .rsp_in_valid(rsp_in_valid),
        .req_in_valid(req_in_valid), .dma_req_in_valid(dma_req_in_valid),
        .rst_stall(rst_stall), .flush_stall(flush_stall), .req_stall(req_stall),
        .req_in_stalled_valid(req_in_stalled_valid), .recall_pending(recall_pending),
        .dma_read_pending(dma_read_pending), .dma_write_pending(dma_write_pending),
        .is_dma_resume(is_dma_resume), .process_done(process_done),
        .rst_in_ready(rst_in_ready), .rsp_in_ready(rsp_in_ready),
        .req_in_ready(req_in_ready), .dma_req_in_ready(dma_req_in_ready),
        .decode_en(decode_en), .grant(grant), .walk_set(walk_set), .walk_done(walk_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 decoding, 2 processing.
    int m_phase = 0;
    int m_src   = 0;
    bit m_rr    = 0;
    int m_walk  = 0;
    bit m_done  = 0;
    int cur_w;
    bit cur_tie;

    function automatic void model_pick(output int w, output bit tie);
        bit e[7];
        bit walking, pend, fresh;
        walking = rst_stall || flush_stall;
        pend    = dma_read_pending || dma_write_pending;
        fresh   = !walking && !req_stall && !recall_pending && !pend;
        e[0] = rst_in_valid && !walking && !recall_pending;
        e[1] = rsp_in_valid;
        e[2] = req_in_stalled_valid && !req_stall && !recall_pending;
        e[3] = is_dma_resume && !recall_pending;
        e[4] = walking && !recall_pending;
        e[5] = req_in_valid && fresh;
        e[6] = dma_req_in_valid && fresh;
        w = -1;
        tie = 0;
        for (int i = 0; i < 5; i++) if (e[i] && w < 0) w = i;
        if (w < 0) begin
            if (e[5] && e[6]) begin
                tie = 1;
                w = m_rr ? 6 : 5;
            end else if (e[5]) w = 5;
            else if (e[6]) w = 6;
        end
    endfunction

    // Compare all DUT outputs against the model at the falling edge.
    task automatic sample();
        logic [3:0] er;
        logic [6:0] eg;
        @(negedge clk);
        model_pick(cur_w, cur_tie);
        er = 4'b0;
        if (!rst && m_phase == 0) begin
            case (cur_w)
                0: er[0] = 1'b1;
                1: er[1] = 1'b1;
                5: er[2] = 1'b1;
                6: er[3] = 1'b1;
                default: ;
            endcase
        end
        eg = (m_phase != 0) ? 7'(1 << m_src) : 7'b0;
        check("ready", {28'b0, dma_req_in_ready, req_in_ready, rsp_in_ready, rst_in_ready}, {28'b0, er});
        check("grant", {25'b0, grant}, {25'b0, eg});
        check("decode_en", {31'b0, decode_en}, {31'b0, (m_phase == 1)});
        check("walk_set", {30'b0, walk_set}, 32'(m_walk));
        check("walk_done", {31'b0, walk_done}, {31'b0, m_done});
    endtask

    // Advance the model and the DUT one clock with the inputs just sampled.
    task automatic tick();
        if (rst) begin
            m_phase = 0; m_rr = 0; m_walk = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_phase == 0) begin
                if (cur_w >= 0) begin
                    m_phase = 1;
                    m_src   = cur_w;
                    if (cur_w == 0) m_walk = 0;
                    if (cur_tie) m_rr = (cur_w == 5);
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else if (process_done) begin
                m_phase = 0;
                if (m_src == 4) begin
                    m_walk = (m_walk + 1) % SETS;
                    if (m_walk == 0) m_done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {rst_in_valid, rsp_in_valid, req_in_valid, dma_req_in_valid} = '0;
        {rst_stall, flush_stall, req_stall, req_in_stalled_valid, recall_pending} = '0;
        {dma_read_pending, dma_write_pending, is_dma_resume, process_done} = '0;
    endtask

    // Flag vector bits: 0 rst_in_valid 1 rsp 2 req 3 dma 4 rst_stall 5 flush_stall
    // 6 req_stall 7 stalled_valid 8 recall 9 dma_rd 10 dma_wr 11 is_dma_resume
    task automatic apply_flags(input logic [11:0] f);
        rst_in_valid = f[0]; rsp_in_valid = f[1]; req_in_valid = f[2]; dma_req_in_valid = f[3];
        rst_stall = f[4]; flush_stall = f[5]; req_stall = f[6]; req_in_stalled_valid = f[7];
        recall_pending = f[8]; dma_read_pending = f[9]; dma_write_pending = f[10];
        is_dma_resume = f[11];
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        sample(); tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [11:0] flags;
        logic [3:0]  rdy;    // {dma, req, rsp, rst}
        logic [6:0]  gnt;
    } vec_t;

    vec_t tbl[12];
    logic [6:0] alt[4];

    initial begin
        rst = 1'b1;
        clear_inputs();
        tbl[0]  = '{12'h004, 4'b0100, 7'b0100000};
        tbl[1]  = '{12'h007, 4'b0001, 7'b0000001};
        tbl[2]  = '{12'h106, 4'b0010, 7'b0000010};
        tbl[3]  = '{12'h104, 4'b0000, 7'b0000000};
        tbl[4]  = '{12'h080, 4'b0000, 7'b0000100};
        tbl[5]  = '{12'h0C4, 4'b0000, 7'b0000000};
        tbl[6]  = '{12'h804, 4'b0000, 7'b0001000};
        tbl[7]  = '{12'h025, 4'b0000, 7'b0010000};
        tbl[8]  = '{12'h008, 4'b1000, 7'b1000000};
        tbl[9]  = '{12'h00C, 4'b0100, 7'b0100000};
        tbl[10] = '{12'h204, 4'b0000, 7'b0000000};
        tbl[11] = '{12'h011, 4'b0000, 7'b0010000};
        alt[0] = 7'b0100000; alt[1] = 7'b1000000; alt[2] = 7'b0100000; alt[3] = 7'b1000000;
        @(posedge clk); #1;

        // Reset for two cycles, then a lone CPU request.
        sample(); tick(); sample(); tick();
        check("reset_outputs", {25'b0, grant, decode_en, walk_done, rst_in_ready, rsp_in_ready}, 32'b0);
        rst = 1'b0;
        req_in_valid = 1'b1;
        sample();
        check("req_ready_T", {31'b0, req_in_ready}, 32'd1);
        tick();
        req_in_valid = 1'b0;
        sample();
        check("req_decode_T1", {31'b0, decode_en}, 32'd1);
        check("req_grant", {25'b0, grant}, 32'b0100000);
        tick();

        // Table: one-shot arbitration from a fresh reset.
        for (int i = 0; i < 12; i++) begin
            do_reset();
            apply_flags(tbl[i].flags);
            sample();
            check($sformatf("tbl%0d_ready", i),
                  {28'b0, dma_req_in_ready, req_in_ready, rsp_in_ready, rst_in_ready}, {28'b0, tbl[i].rdy});
            tick();
            clear_inputs();
            sample();
            check($sformatf("tbl%0d_grant", i), {25'b0, grant}, {25'b0, tbl[i].gnt});
            check($sformatf("tbl%0d_decode", i), {31'b0, decode_en}, {31'b0, (tbl[i].gnt != 0)});
            tick();
        end

        // CPU and DMA both pending: grants alternate.
        do_reset();
        req_in_valid = 1'b1; dma_req_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample(); tick();
            sample();
            check($sformatf("rr_grant%0d", k), {25'b0, grant}, {25'b0, alt[k]});
            tick();
            sample(); tick();
            process_done = 1'b1;
            sample(); tick();
            process_done = 1'b0;
        end

        // Recall outstanding: only the response is popped.
        do_reset();
        recall_pending = 1'b1; req_in_valid = 1'b1; rsp_in_valid = 1'b1;
        sample();
        check("recall_rsp_ready", {30'b0, rsp_in_ready, req_in_ready}, 32'b10);
        tick();
        rsp_in_valid = 1'b0;
        sample(); tick();
        process_done = 1'b1;
        sample(); tick();
        process_done = 1'b0;
        sample();
        check("recall_req_blocked", {31'b0, req_in_ready}, 32'd0);
        tick();
        recall_pending = 1'b0;
        sample();
        check("recall_req_released", {31'b0, req_in_ready}, 32'd1);
        tick();
        req_in_valid = 1'b0;
        sample(); tick();

        // Flush walk over all four sets.
        do_reset();
        flush_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("walk_done_quiet%0d", k), {31'b0, walk_done}, 32'd0);
            tick();
            sample();
            check($sformatf("walk_grant%0d", k), {25'b0, grant}, 32'b0010000);
            check($sformatf("walk_set%0d", k), {30'b0, walk_set}, 32'(k));
            tick();
            process_done = 1'b1;
            sample(); tick();
            process_done = 1'b0;
        end
        flush_stall = 1'b0;
        sample();
        check("walk_done_pulse", {31'b0, walk_done}, 32'd1);
        check("walk_wrap", {30'b0, walk_set}, 32'd0);
        tick();
        sample();
        check("walk_done_once", {31'b0, walk_done}, 32'd0);
        tick();

        // Reset during BUSY aborts the grant.
        do_reset();
        req_in_valid = 1'b1;
        sample(); tick();
        req_in_valid = 1'b0;
        sample(); tick();
        sample(); tick();
        rst = 1'b1;
        req_in_valid = 1'b1;
        sample();
        check("busy_rst_no_pop", {31'b0, req_in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        req_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            check($sformatf("busy_rst_idle%0d", k),
                  {23'b0, grant, decode_en, req_in_ready}, 32'd0);
            tick();
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst                  = ($urandom_range(0, 99) < 2);
            rst_in_valid         = ($urandom_range(0, 99) < 15);
            rsp_in_valid         = ($urandom_range(0, 99) < 25);
            req_in_valid         = ($urandom_range(0, 99) < 60);
            dma_req_in_valid     = ($urandom_range(0, 99) < 50);
            rst_stall            = ($urandom_range(0, 99) < 5);
            flush_stall          = ($urandom_range(0, 99) < 10);
            req_stall            = ($urandom_range(0, 99) < 15);
            req_in_stalled_valid = ($urandom_range(0, 99) < 15);
            recall_pending       = ($urandom_range(0, 99) < 10);
            dma_read_pending     = ($urandom_range(0, 99) < 10);
            dma_write_pending    = ($urandom_range(0, 99) < 10);
            is_dma_resume        = ($urandom_range(0, 99) < 10);
            process_done         = ($urandom_range(0, 99) < 40);
            sample(); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
